uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
- Runs on the system clock; `s_tick` is a one-cycle baud-oversample enable from the baud generator.
- Data width, parity mode, stop-bit count and oversample ratio are configurable; a valid/ready handshake accepts frames.
- Sits between the TX FIFO/host interface and the serial pin.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- OVERSAMPLE, 16, `s_tick` pulses per bit period; legal 2..256.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- s_tick  input  1  oversample enable, one clk wide.
- data_in  input  DATA_BITS  payload; sampled only on acceptance.
- valid  input  1  producer has a frame to send.
- ready  output  1  block can accept a frame; combinational = (state==IDLE) && !reset.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-clk pulse at end of final stop bit.

Behaviour:
- Reset (synchronous, active-high), applied on next clk edge:
  - tx=1, busy=0, tx_done=0.
  - State=IDLE; tick counter=0; bit index=0; shift register cleared.
  - Reset mid-frame aborts the frame: tx returns high on that edge, no tx_done pulse.
- States and transitions:
  - IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Acceptance:
  - A frame is accepted on a clk edge with valid && ready.
  - On that edge: data_in latched, parity computed, state=START, tx=0, busy=1, tick counter=0.
  - `valid` while busy is ignored; `data_in` changes after acceptance do not affect the frame.
- Bit timing:
  - A tick counter counts `s_tick` pulses.
  - A bit period ends on the clk edge where s_tick=1 and counter==OVERSAMPLE-1. On that edge the counter wraps to 0 and the next bit is driven on tx.
  - Clk cycles without `s_tick` hold all state.
- DATA state:
  - LSB first; bit index runs 0..DATA_BITS-1.
  - After bit DATA_BITS-1 completes, go to PARITY (or STOP when PARITY=0).
- PARITY state:
  - Odd mode: tx = ~^data, so the count of ones over data plus parity is odd.
  - Even mode: tx = ^data.
  - Width is 1 bit.
- STOP state:
  - tx=1 for STOP_BITS bit periods.
  - On the edge ending the last stop period: state=IDLE, busy=0, tx_done=1 for exactly that one following cycle, tx stays 1.
- Frame length: exactly OVERSAMPLE*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) `s_tick` pulses from acceptance edge to the tx_done edge.
- Back-to-back:
  - `ready` rises in the same cycle tx_done is high.
  - If valid is held, the next frame is accepted that cycle; the start bit follows the stop bit with no extra idle period.
- Simultaneous events:
  - reset && valid: reset wins, nothing accepted.
  - s_tick on the acceptance edge is not counted toward the start bit.
- Illegal parameter values: flag at elaboration with $error.

Test Plan:
- 8N1, OVERSAMPLE=16, s_tick every clk, send 0xA5:
  - Required: tx = 0, 1,0,1,0,0,1,0,1, 1.
  - Each level lasts 16 clk; tx_done pulses once, 160 clk after acceptance.
- DATA_BITS=7, PARITY=2 (even), send 7'h53 (four ones):
  - Required: parity bit 0; frame 10 bits; tx_done once.
- DATA_BITS=8, PARITY=1 (odd), STOP_BITS=2, send 0x07 (three ones):
  - Required: parity bit 0; stop high for 32 ticks; total 12 bit periods.
- s_tick every 5th clk, valid held high with data 0x11 then 0x22:
  - Required: two frames, no idle gap between them.
  - Each frame takes 160 `s_tick` pulses; ready high only in the tx_done cycles; second frame carries 0x22.
- Change data_in and pulse valid mid-frame:
  - Required: transmitted bits match originally latched data; ready stays 0.
- Assert reset during DATA bit 3 (8N1):
  - Required: tx=1 and busy=0 on next edge, no tx_done.
  - A new frame sent afterwards is bit-exact.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS payload (LSB first),
// optional parity, STOP_BITS stop bits; bit periods paced by s_tick.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 2 || OVERSAMPLE > 256) begin : g_bad_oversample
    $error("uart_tx_frame: OVERSAMPLE must be 2..256");
  end

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  assign bit_end = s_tick && (tick_q == TW'(OVERSAMPLE - 1));
  assign ready   = (state_q == IDLE) && !reset;
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = done_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    // Tick on the acceptance edge is deliberately not counted.
    if (state_q != IDLE && s_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (valid) begin
          sh_d    = data_in;
          par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
          state_d = START;
          tx_d    = 1'b0;
          tick_d  = '0;
          idx_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == 4'(STOP_BITS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised bench for uart_tx_frame: four configurations checked
// cycle by cycle against a frame model built from the bit list.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic [8:0] data_r;
  logic       valid_w [4];
  logic       ready_w [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int db_a  [4] = '{8, 7, 8, 9};
  int par_a [4] = '{0, 2, 1, 1};
  int sb_a  [4] = '{1, 1, 2, 1};
  int os_a  [4] = '{16, 16, 16, 3};

  int n_tests = 0;
  int n_fail  = 0;
  int tick_div = 1;
  int tick_cnt = 0;
  bit tk;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .data_in(data_r[7:0]), .valid(valid_w[0]), .ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
                  .OVERSAMPLE(16)) u_7e1 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .data_in(data_r[6:0]), .valid(valid_w[1]), .ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                  .OVERSAMPLE(16)) u_8o2 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .data_in(data_r[7:0]), .valid(valid_w[2]), .ready(ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_frame #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1),
                  .OVERSAMPLE(3)) u_9o1 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .data_in(data_r[8:0]), .valid(valid_w[3]), .ready(ready_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: note whether s_tick was high at the edge, then
  // drive the next s_tick value and return 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    tk = s_tick;
    #1;
    tick_cnt++;
    if (tick_div == 0) s_tick = 1'($urandom_range(0, 1));
    else s_tick = ((tick_cnt % tick_div) == 0);
  endtask

  // mode 0: valid dropped after accept; 1: random valid/data
  // disturbance mid-frame; 2: valid held high through the frame.
  task automatic send(input int k, input logic [8:0] d, input int mode,
                      input int max_wait, output int waited);
    logic bits[$];
    int ones, total, ticks, cyc_n, os;
    os = os_a[k];
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < db_a[k]; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par_a[k] == 1) bits.push_back((ones % 2) == 0);
    if (par_a[k] == 2) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < sb_a[k]; i++) bits.push_back(1'b1);
    total = os * bits.size();

    waited = 0;
    while (!ready_w[k] && waited < max_wait) begin
      cyc();
      waited++;
    end
    chk("ready_before_accept", ready_w[k], 1);
    data_r = d;
    valid_w[k] = 1'b1;
    cyc();
    chk("accept_tx_low", tx_w[k], 0);
    chk("accept_busy", busy_w[k], 1);
    chk("accept_done_low", done_w[k], 0);

    ticks = 0;
    cyc_n = 0;
    while (ticks < total && cyc_n < total * 64) begin
      valid_w[k] = (mode == 2) ? 1'b1 :
                   (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 1) data_r = 9'($urandom);
      cyc();
      cyc_n++;
      if (tk) ticks++;
      if (ticks < total) begin
        chk("tx_bit", tx_w[k], bits[ticks / os]);
        chk("busy_mid", busy_w[k], 1);
        chk("ready_mid", ready_w[k], 0);
        chk("done_early", done_w[k], 0);
      end
    end
    chk("frame_ticks", ticks, total);
    chk("done_pulse", done_w[k], 1);
    chk("done_tx_high", tx_w[k], 1);
    chk("done_busy_low", busy_w[k], 0);
    chk("done_ready", ready_w[k], 1);
    if (tick_div == 1) chk("frame_clks", cyc_n, total);
    if (mode != 2) valid_w[k] = 1'b0;
  endtask

  task automatic idle_check(input int k);
    cyc();
    chk("idle_done_low", done_w[k], 0);
    chk("idle_tx_high", tx_w[k], 1);
    chk("idle_busy_low", busy_w[k], 0);
  endtask

  initial begin
    int w, w2, ticks, k, guard;
    logic [8:0] d;
    reset = 1'b1;
    s_tick = 1'b0;
    data_r = '0;
    for (int i = 0; i < 4; i++) valid_w[i] = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx_w[i], 1);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_done", done_w[i], 0);
      chk("rst_ready", ready_w[i], 0);
    end
    reset = 1'b0;
    cyc();
    chk("post_rst_ready", ready_w[0], 1);

    tick_div = 1;
    send(0, 9'h0A5, 0, 50, w);
    idle_check(0);
    send(1, 9'h053, 0, 50, w);
    idle_check(1);
    send(2, 9'h007, 0, 50, w);
    idle_check(2);

    // back-to-back with valid held, slow ticks
    tick_div = 5;
    send(0, 9'h011, 2, 50, w);
    send(0, 9'h022, 0, 0, w2);
    chk("b2b_no_gap", w2, 0);
    idle_check(0);

    // disturbance mid-frame, random tick spacing
    tick_div = 0;
    send(0, 9'($urandom), 1, 50, w);
    idle_check(0);
    send(3, 9'($urandom), 1, 50, w);
    idle_check(3);

    // reset in the middle of data bit 3
    tick_div = 1;
    data_r = 9'($urandom);
    valid_w[0] = 1'b1;
    cyc();
    valid_w[0] = 1'b0;
    ticks = 0;
    guard = 0;
    while (ticks < 16 * 4 + 8 && guard < 1000) begin
      cyc();
      guard++;
      if (tk) ticks++;
    end
    chk("abort_in_frame", busy_w[0], 1);
    reset = 1'b1;
    #1;
    chk("ready_in_reset", ready_w[0], 0);
    cyc();
    chk("abort_tx", tx_w[0], 1);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_done", done_w[0], 0);
    valid_w[0] = 1'b1;
    cyc();
    chk("rst_valid_busy", busy_w[0], 0);
    reset = 1'b0;
    valid_w[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("abort_no_done", done_w[0], 0);
    end
    send(0, 9'($urandom), 0, 50, w);
    idle_check(0);

    // random frames across all configurations
    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 3);
      d = 9'($urandom);
      case ($urandom_range(0, 2))
        0: tick_div = 0;
        1: tick_div = 1;
        default: tick_div = 3;
      endcase
      send(k, d, $urandom_range(0, 1), 50, w);
      idle_check(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
